// File: rtl/mdu_core.sv
// -----------------------------------------------------------------------------
// mdu_core -- multiply/divide unit holding the HI/LO register pair.
//
// A multiply- or divide-class op launches when the unit is idle. The result is
// computed at launch, held in shadow registers, and written to HI/LO only when
// the busy countdown finishes. Until then, mfhi/mflo read the old committed values.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (and madd-class ops), legal 1..15
//   DIV_CYCLES   busy cycles for div/divu, legal 1..15
//
// Optional feature:
//   MDU_MADD_EN  when defined, ops 9..12 (madd, maddu, msub, msubu) accumulate
//                into {HI,LO}. When undefined, those codes behave as "none".
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset; clears HI, LO, shadows and counter
//   req     flush of the E-stage instruction; blocks launch and mthi/mtlo
//   start   qualifies a multiply/divide-class op this cycle
//   op      0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//           7 mfhi, 8 mflo, 9 madd, 10 maddu, 11 msub, 12 msubu, 13-15 none
//   A, B    rs / rt operands
//   busy    an operation is in flight (hl_busy for the stall unit)
//   hl_out  combinational HI (op=7) or LO (op=8) read data, otherwise 0
//
// Handshake: an op is accepted on a rising edge where start=1, req=0, busy=0
// and op is a launchable code. Accepted means busy is high for exactly N
// cycles from that edge. While busy=1 the unit ignores start and mthi/mtlo.
// The stall unit must hold off new ops until busy falls.
// -----------------------------------------------------------------------------
module mdu_core #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hl_out
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    // Control state lives in a single packed struct so the phase and the
    // countdown can be observed together as one signal.
    typedef enum logic {
        PH_IDLE = 1'b0,
        PH_BUSY = 1'b1
    } phase_t;

    typedef struct packed {
        phase_t     phase;
        logic [3:0] count;      // remaining busy cycles
        logic       commit_en;  // 0 for divide-by-zero: HI/LO are left alone
    } ctl_t;

    ctl_t        ctl;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] sh_hi;
    logic [31:0] sh_lo;

    // ---------------------------------------------------------------------
    // Datapath: results are computed from operands present at launch.
    // ---------------------------------------------------------------------
    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] a_zx;
    logic [63:0] b_zx;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign a_sx = {{32{A[31]}}, A};
    assign b_sx = {{32{B[31]}}, B};
    assign a_zx = {32'd0, A};
    assign b_zx = {32'd0, B};

    // The low 64 bits of the product of the sign-extended operands equal the
    // two's-complement signed product.
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // One unsigned divider serves both div and divu. For div, it operates on
    // magnitudes. The magnitude of 0x80000000 is 2^31, which is still
    // representable unsigned, so the overflow case needs no special path.
    logic        div_signed;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic        b_zero;

    assign div_signed = (op == OP_DIV);
    assign b_zero     = (B == 32'd0);
    assign dvd        = (div_signed && A[31]) ? (~A + 32'd1) : A;
    // A zero divisor is replaced by 1 so the divider output is always defined.
    // The result is then discarded through commit_en.
    assign dvs        = b_zero ? 32'd1 :
                        ((div_signed && B[31]) ? (~B + 32'd1) : B);
    assign q_mag      = dvd / dvs;
    assign r_mag      = dvd % dvs;
    // The quotient truncates toward zero. The remainder follows the sign of the dividend.
    assign q_s        = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s        = A[31] ? (~r_mag + 32'd1) : r_mag;

    // Launch decode and the value each op would commit.
    logic        launch_ok;
    logic [3:0]  n_load;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_commit;

    always_comb begin
        launch_ok  = 1'b0;
        n_load     = MULT_N;
        res_hi     = hi;
        res_lo     = lo;
        res_commit = 1'b1;
        case (op)
            OP_MULT: begin
                launch_ok        = 1'b1;
                {res_hi, res_lo} = prod_s;
            end
            OP_MULTU: begin
                launch_ok        = 1'b1;
                {res_hi, res_lo} = prod_u;
            end
            OP_DIV: begin
                launch_ok  = 1'b1;
                n_load     = DIV_N;
                res_commit = ~b_zero;
                res_lo     = q_s;
                res_hi     = r_s;
            end
            OP_DIVU: begin
                launch_ok  = 1'b1;
                n_load     = DIV_N;
                res_commit = ~b_zero;
                res_lo     = q_mag;
                res_hi     = r_mag;
            end
`ifdef MDU_MADD_EN
            // Accumulation uses the committed HI/LO at launch time. Arithmetic wraps modulo 2^64.
            OP_MADD: begin
                launch_ok        = 1'b1;
                {res_hi, res_lo} = {hi, lo} + prod_s;
            end
            OP_MADDU: begin
                launch_ok        = 1'b1;
                {res_hi, res_lo} = {hi, lo} + prod_u;
            end
            OP_MSUB: begin
                launch_ok        = 1'b1;
                {res_hi, res_lo} = {hi, lo} - prod_s;
            end
            OP_MSUBU: begin
                launch_ok        = 1'b1;
                {res_hi, res_lo} = {hi, lo} - prod_u;
            end
`endif
            default: begin
                launch_ok = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Control FSM and HI/LO state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl   <= '{phase: PH_IDLE, count: 4'd0, commit_en: 1'b0};
            hi    <= 32'd0;
            lo    <= 32'd0;
            sh_hi <= 32'd0;
            sh_lo <= 32'd0;
        end else begin
            case (ctl.phase)
                PH_IDLE: begin
                    if (!req) begin
                        if (start && launch_ok) begin
                            sh_hi <= res_hi;
                            sh_lo <= res_lo;
                            ctl   <= '{phase: PH_BUSY, count: n_load,
                                       commit_en: res_commit};
                        end else if (op == OP_MTHI) begin
                            hi <= A;
                        end else if (op == OP_MTLO) begin
                            lo <= A;
                        end
                    end
                end
                PH_BUSY: begin
                    // Start, mthi/mtlo and req do not affect an op that is in flight.
                    // The "<= 1" test also covers a zero count, so the counter never wraps.
                    if (ctl.count <= 4'd1) begin
                        if (ctl.commit_en) begin
                            hi <= sh_hi;
                            lo <= sh_lo;
                        end
                        ctl <= '{phase: PH_IDLE, count: 4'd0, commit_en: 1'b0};
                    end else begin
                        ctl.count <= ctl.count - 4'd1;
                    end
                end
                default: begin
                    ctl <= '{phase: PH_IDLE, count: 4'd0, commit_en: 1'b0};
                end
            endcase
        end
    end

    assign busy = (ctl.phase == PH_BUSY);

    // hl_out reads only the committed HI/LO. The shadow registers are never visible here.
    always_comb begin
        hl_out = 32'd0;
        case (op)
            OP_MFHI: hl_out = hi;
            OP_MFLO: hl_out = lo;
            default: hl_out = 32'd0;
        endcase
    end

endmodule

// File: doc/mdu_core.md
MDU_CORE -- requirements
Module: mdu_core

Interface
REQ-001 The block SHALL take parameter MULT_CYCLES, default 5, meaning busy cycles for a multiply-class op (legal range 1..15).
REQ-002 The block SHALL take parameter DIV_CYCLES, default 10, meaning busy cycles for a divide-class op (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, 1 bit: exception/interrupt flush of the E-stage instruction.
REQ-006 The block SHALL have port start, input, 1 bit: qualifies a multiply/divide-class op this cycle.
REQ-007 The block SHALL have port op, input, 4 bits: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 are treated as none.
REQ-008 The block SHALL have port A, input, 32 bits: rs operand.
REQ-009 The block SHALL have port B, input, 32 bits: rt operand.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in flight; this is the hl_busy consumed by the stall unit.
REQ-011 The block SHALL have port hl_out, output, 32 bits: HI or LO read data for mfhi/mflo.

Function
REQ-012 Launch: at a rising edge with start=1, req=0, busy=0 and op in {1,2,3,4,9..12}, the block SHALL latch the computed result into shadow registers, load the counter with N (MULT_CYCLES or DIV_CYCLES), and set busy=1 from that edge.
REQ-013 Counting: the counter SHALL decrement each edge while busy; at the edge where it reaches 0, the shadow values SHALL commit to HI/LO and busy SHALL fall in the same edge, giving busy high for exactly N cycles.
REQ-014 The block SHALL ignore start while busy=1 (the stall unit guarantees this never occurs); the in-flight op SHALL be unaffected.
REQ-015 For mult/multu, {HI,LO} SHALL equal the 64-bit signed/unsigned product of A and B.
REQ-016 For div, LO SHALL be the quotient truncated toward zero and HI the remainder carrying the sign of the dividend; 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-017 For divu, the quotient and remainder SHALL be unsigned.
REQ-018 On divide by zero (B=0), the op SHALL still hold busy for DIV_CYCLES, and HI/LO SHALL stay unchanged at commit.
REQ-019 mthi/mtlo with req=0 SHALL write A to HI/LO at that edge with zero latency, regardless of start; if busy=1 they SHALL be ignored.
REQ-020 hl_out SHALL be combinational: HI when op=7, LO when op=8, otherwise 0; it SHALL reflect committed HI/LO only, never shadow values.
REQ-021 Flush: req=1 SHALL suppress launch and mthi/mtlo in that cycle; an op already in flight SHALL run to commit.
REQ-022 The counter SHALL be 4 bits with no wrap; busy SHALL never be high for more than N cycles.

Reset
REQ-023 On reset=1, the block SHALL asynchronously clear HI, LO, the shadow registers and the counter to 0 and set busy=0, including mid-operation; the pending result SHALL be discarded.
REQ-024 After reset deasserts, the first edge SHALL be able to launch an op.

Configuration
REQ-025 With MDU_MADD_EN defined, ops 9-12 SHALL be enabled and SHALL compute {HI,LO} +/- the signed (9,11) or unsigned (10,12) product of A and B, modulo 2^64, using MULT_CYCLES latency.
REQ-026 Without MDU_MADD_EN, ops 9-12 SHALL be treated as none: no launch, no busy, HI/LO unchanged.

Verification
REQ-027 mult with A=0xFFFFFFFE, B=3, start=1 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi reads 0xFFFFFFFF.
REQ-028 div with A=0xFFFFFFF9 (-7), B=2 -> busy high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with B=0 -> HI/LO unchanged.
REQ-029 mtlo A=0x1234 with req=1 -> LO unchanged; the same op with req=0 -> mflo returns 0x1234 in the following cycle.
REQ-030 multu launched, reset asserted at busy cycle 3 -> busy=0 and HI=LO=0 immediately; no commit after reset releases.
REQ-031 Second start during busy, plus mthi during busy -> both ignored; the first result commits on schedule.
REQ-032 With MDU_MADD_EN, HI:LO=0:0xFFFFFFFF, maddu A=1, B=1 -> HI=1, LO=0; without the macro, HI/LO unchanged and busy stays 0.
